// File: rtl/coalescing_store_buffer.sv
// Circular store buffer: in-order allocation, resolve/commit tracking, head drain with
// two-entry same-word coalescing, and byte-granular store-to-load forwarding.
module coalescing_store_buffer #(
  parameter int SB_DEPTH      = 16,
  parameter int ALLOC_WIDTH   = 4,
  parameter int COMMIT_WIDTH  = 4,
  parameter int ROB_IDX_WIDTH = 6,
  parameter int PLEN          = 32,
  parameter int XLEN          = 32,
  localparam int IDW  = $clog2(SB_DEPTH),
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB),
  localparam int WAW  = PLEN - OFFW,
  localparam int NW   = $clog2(ALLOC_WIDTH + 1)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        flush_i,
  input  logic [ALLOC_WIDTH-1:0]      alloc_req_i,
  input  logic                        alloc_fire_i,
  output logic                        alloc_ready_o,
  output logic [ALLOC_WIDTH*IDW-1:0]  alloc_id_o,
  input  logic                        ex_valid_i,
  input  logic [IDW-1:0]              ex_sb_id_i,
  input  logic [PLEN-1:0]             ex_addr_i,
  input  logic [XLEN-1:0]             ex_data_i,
  input  logic [1:0]                  ex_size_i,
  input  logic [ROB_IDX_WIDTH-1:0]    ex_rob_idx_i,
  input  logic [COMMIT_WIDTH-1:0]     commit_valid_i,
  input  logic [COMMIT_WIDTH*IDW-1:0] commit_sb_id_i,
  output logic                        dc_req_valid_o,
  input  logic                        dc_req_ready_i,
  output logic [PLEN-1:0]             dc_req_addr_o,
  output logic [XLEN-1:0]             dc_req_data_o,
  output logic [NB-1:0]               dc_req_be_o,
  input  logic [PLEN-1:0]             ld_addr_i,
  input  logic [1:0]                  ld_size_i,
  input  logic [ROB_IDX_WIDTH-1:0]    ld_rob_idx_i,
  input  logic [ROB_IDX_WIDTH-1:0]    rob_head_i,
  output logic [NB-1:0]               ld_fwd_be_o,
  output logic [XLEN-1:0]             ld_fwd_data_o,
  output logic                        ld_unknown_o,
  output logic [IDW:0]                count_o
);

  function automatic logic [NB-1:0] f_mask(input logic [1:0] size, input logic [OFFW-1:0] off);
    logic [NB-1:0] m;
    case (size)
      2'd0:    m = NB'(1);
      2'd1:    m = NB'(3);
      2'd2:    m = NB'(15);
      default: m = '1;
    endcase
    return m << off;
  endfunction

  logic [SB_DEPTH-1:0]      r_valid, r_commit, r_resolved;
  logic [IDW-1:0]           r_head, r_tail;
  logic [IDW:0]             r_count;
  logic                     r_lock, r_lock_merge;
  logic [WAW-1:0]           r_waddr [SB_DEPTH];
  logic [XLEN-1:0]          r_data  [SB_DEPTH];
  logic [NB-1:0]            r_be    [SB_DEPTH];
  logic [ROB_IDX_WIDTH-1:0] r_rob   [SB_DEPTH];

  logic [NW-1:0]            w_n;
  logic [IDW-1:0]           w_alloc_id [ALLOC_WIDTH];
  logic                     w_alloc_do;
  logic [SB_DEPTH-1:0]      w_commit_set, w_popped, w_keep;
  logic [SB_DEPTH-1:0]      w_valid_n, w_commit_n, w_res_n;
  logic [IDW-1:0]           w_h1, w_head_n, w_tail_n;
  logic [IDW:0]             w_count_n, w_kcount;
  logic                     w_rdy0, w_rdy1, w_merge, w_accept;
  logic [1:0]               w_npop;
  logic [NB-1:0]            w_ld_mask;

  always_comb begin
    w_n = '0;
    for (int l = 0; l < ALLOC_WIDTH; l++) begin
      w_alloc_id[l] = '0;
      if (alloc_req_i[l]) begin
        w_alloc_id[l] = r_tail + IDW'(w_n);
        w_n = w_n + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < ALLOC_WIDTH; g++) begin : g_id
    assign alloc_id_o[g*IDW +: IDW] = w_alloc_id[g];
  end

  // Readiness looks only at the registered count, so a same-cycle drain never frees space early
  assign alloc_ready_o = (int'(r_count) + int'(w_n)) <= SB_DEPTH;
  assign w_alloc_do    = alloc_fire_i & alloc_ready_o & ~flush_i;

  always_comb begin
    w_commit_set = '0;
    for (int l = 0; l < COMMIT_WIDTH; l++)
      if (commit_valid_i[l]) w_commit_set[commit_sb_id_i[l*IDW +: IDW]] = 1'b1;
  end

  assign w_h1     = r_head + 1'b1;
  assign w_rdy0   = r_valid[r_head] & r_commit[r_head] & r_resolved[r_head];
  assign w_rdy1   = r_valid[w_h1] & r_commit[w_h1] & r_resolved[w_h1] &
                    (r_waddr[w_h1] == r_waddr[r_head]) & (r_count >= (IDW+1)'(2));
  // A request stalled by the cache keeps its original merge decision so its contents never change
  assign w_merge  = w_rdy0 & (r_lock ? r_lock_merge : w_rdy1);
  assign w_accept = w_rdy0 & dc_req_ready_i;
  assign w_npop   = {w_accept & w_merge, w_accept & ~w_merge};
  assign w_head_n = r_head + IDW'(w_npop);

  always_comb begin
    w_popped = '0;
    if (w_accept) w_popped[r_head] = 1'b1;
    if (w_accept && w_merge) w_popped[w_h1] = 1'b1;
  end

  assign dc_req_valid_o = w_rdy0;
  assign dc_req_addr_o  = w_rdy0 ? {r_waddr[r_head], OFFW'(0)} : '0;

  always_comb begin
    dc_req_be_o   = '0;
    dc_req_data_o = '0;
    for (int b = 0; b < NB; b++) begin
      if (w_rdy0 && r_be[r_head][b]) begin
        dc_req_be_o[b]        = 1'b1;
        dc_req_data_o[8*b +: 8] = r_data[r_head][8*b +: 8];
      end
      if (w_merge && r_be[w_h1][b]) begin
        dc_req_be_o[b]        = 1'b1;
        dc_req_data_o[8*b +: 8] = r_data[w_h1][8*b +: 8];
      end
    end
  end

  assign w_keep = r_valid & (r_commit | w_commit_set) & ~w_popped;

  always_comb begin
    w_kcount = '0;
    for (int i = 0; i < SB_DEPTH; i++) w_kcount = w_kcount + (IDW+1)'(w_keep[i]);
  end

  always_comb begin
    w_valid_n  = r_valid & ~w_popped;
    w_commit_n = (r_commit | w_commit_set) & ~w_popped;
    w_res_n    = r_resolved & ~w_popped;
    w_tail_n   = r_tail;
    w_count_n  = r_count - (IDW+1)'(w_npop);
    if (flush_i) begin
      // Surviving committed entries are contiguous from the new head
      w_valid_n  = w_keep;
      w_commit_n = w_keep;
      w_res_n    = r_resolved & w_keep;
      w_tail_n   = w_head_n + w_kcount[IDW-1:0];
      w_count_n  = w_kcount;
    end else begin
      if (w_alloc_do) begin
        for (int l = 0; l < ALLOC_WIDTH; l++) begin
          if (alloc_req_i[l]) begin
            w_valid_n[w_alloc_id[l]]  = 1'b1;
            w_commit_n[w_alloc_id[l]] = 1'b0;
            w_res_n[w_alloc_id[l]]    = 1'b0;
          end
        end
        w_tail_n  = r_tail + IDW'(w_n);
        w_count_n = w_count_n + (IDW+1)'(w_n);
      end
      if (ex_valid_i) w_res_n[ex_sb_id_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid      <= '0;
      r_commit     <= '0;
      r_resolved   <= '0;
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      r_lock       <= 1'b0;
      r_lock_merge <= 1'b0;
    end else begin
      r_valid      <= w_valid_n;
      r_commit     <= w_commit_n;
      r_resolved   <= w_res_n;
      r_head       <= w_head_n;
      r_tail       <= w_tail_n;
      r_count      <= w_count_n;
      r_lock       <= w_rdy0 & ~dc_req_ready_i;
      r_lock_merge <= w_merge;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ex_valid_i && !flush_i) begin
      r_waddr[ex_sb_id_i] <= ex_addr_i[PLEN-1:OFFW];
      r_data[ex_sb_id_i]  <= ex_data_i << {ex_addr_i[OFFW-1:0], 3'b000};
      r_be[ex_sb_id_i]    <= f_mask(ex_size_i, ex_addr_i[OFFW-1:0]);
      r_rob[ex_sb_id_i]   <= ex_rob_idx_i;
    end
  end

  assign w_ld_mask = f_mask(ld_size_i, ld_addr_i[OFFW-1:0]);

  // Walk oldest to youngest so the youngest qualifying store wins each byte
  always_comb begin
    logic [IDW-1:0]           idx;
    logic [ROB_IDX_WIDTH-1:0] ld_age;
    logic                     older;
    ld_fwd_be_o   = '0;
    ld_fwd_data_o = '0;
    ld_age        = ld_rob_idx_i - rob_head_i;
    for (int i = 0; i < SB_DEPTH; i++) begin
      idx   = r_head + IDW'(i);
      older = r_commit[idx] | ((r_rob[idx] - rob_head_i) < ld_age);
      if (r_valid[idx] && r_resolved[idx] && older && (r_waddr[idx] == ld_addr_i[PLEN-1:OFFW])) begin
        for (int b = 0; b < NB; b++) begin
          if (r_be[idx][b] && w_ld_mask[b]) begin
            ld_fwd_be_o[b]          = 1'b1;
            ld_fwd_data_o[8*b +: 8] = r_data[idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign ld_unknown_o = |(r_valid & ~r_resolved);
  assign count_o      = r_count;

endmodule

// File: tb/tb_coalescing_store_buffer.sv
// Directed bench for coalescing_store_buffer: allocation vector table plus hand-written
// sequences for coalescing, forwarding, full/stall, flush and wrap-around merge.
module tb_coalescing_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [3:0]  alloc_req;
  logic        alloc_fire;
  logic        alloc_ready;
  logic [15:0] alloc_id;
  logic        ex_valid;
  logic [3:0]  ex_id;
  logic [31:0] ex_addr, ex_data;
  logic [1:0]  ex_size;
  logic [5:0]  ex_rob;
  logic [3:0]  cm_valid;
  logic [15:0] cm_id;
  logic        dc_valid, dc_ready;
  logic [31:0] dc_addr, dc_data;
  logic [3:0]  dc_be;
  logic [31:0] ld_addr;
  logic [1:0]  ld_size;
  logic [5:0]  ld_rob, rob_head;
  logic [3:0]  fwd_be;
  logic [31:0] fwd_data;
  logic        ld_unknown;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coalescing_store_buffer dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alloc_req_i(alloc_req), .alloc_fire_i(alloc_fire), .alloc_ready_o(alloc_ready), .alloc_id_o(alloc_id),
    .ex_valid_i(ex_valid), .ex_sb_id_i(ex_id), .ex_addr_i(ex_addr), .ex_data_i(ex_data),
    .ex_size_i(ex_size), .ex_rob_idx_i(ex_rob),
    .commit_valid_i(cm_valid), .commit_sb_id_i(cm_id),
    .dc_req_valid_o(dc_valid), .dc_req_ready_i(dc_ready), .dc_req_addr_o(dc_addr),
    .dc_req_data_o(dc_data), .dc_req_be_o(dc_be),
    .ld_addr_i(ld_addr), .ld_size_i(ld_size), .ld_rob_idx_i(ld_rob), .rob_head_i(rob_head),
    .ld_fwd_be_o(fwd_be), .ld_fwd_data_o(fwd_data), .ld_unknown_o(ld_unknown), .count_o(count)
  );

  typedef struct {
    logic [3:0]  req;
    logic        fire;
    logic        exp_rdy;
    logic [15:0] exp_ids;
    logic [4:0]  exp_cnt;
  } avec_t;

  avec_t tbl [10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; alloc_req = 0; alloc_fire = 0; ex_valid = 0; ex_id = 0; ex_addr = 0;
    ex_data = 0; ex_size = 0; ex_rob = 0; cm_valid = 0; cm_id = 0; dc_ready = 0;
    ld_addr = 0; ld_size = 0; ld_rob = 0; rob_head = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
  endtask

  task automatic alloc(input logic [3:0] req);
    alloc_req = req; alloc_fire = 1;
    tick();
    alloc_req = 0; alloc_fire = 0;
  endtask

  task automatic ex(input logic [3:0] id, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] sz, input logic [5:0] rob);
    ex_valid = 1; ex_id = id; ex_addr = a; ex_data = d; ex_size = sz; ex_rob = rob;
    tick();
    ex_valid = 0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic [5:0] rob);
    ld_addr = a; ld_size = sz; ld_rob = rob;
    #1;
  endtask

  initial begin
    tbl[0] = '{4'b1011, 1'b1, 1'b1, 16'h2010, 5'd3};
    tbl[1] = '{4'b1111, 1'b1, 1'b1, 16'h6543, 5'd7};
    tbl[2] = '{4'b0000, 1'b1, 1'b1, 16'h0000, 5'd7};
    tbl[3] = '{4'b0110, 1'b1, 1'b1, 16'h0870, 5'd9};
    tbl[4] = '{4'b1111, 1'b0, 1'b1, 16'hCBA9, 5'd9};
    tbl[5] = '{4'b1111, 1'b1, 1'b1, 16'hCBA9, 5'd13};
    tbl[6] = '{4'b1111, 1'b1, 1'b0, 16'h0FED, 5'd13};
    tbl[7] = '{4'b0111, 1'b1, 1'b1, 16'h0FED, 5'd16};
    tbl[8] = '{4'b0001, 1'b1, 1'b0, 16'h0000, 5'd16};
    tbl[9] = '{4'b0000, 1'b0, 1'b1, 16'h0000, 5'd16};

    // reset state
    rst_n = 0;
    idle();
    #2;
    chk("rst_alloc_ready", alloc_ready, 1);
    chk("rst_dc_valid", dc_valid, 0);
    chk("rst_fwd_be", fwd_be, 0);
    chk("rst_fwd_data", fwd_data, 0);
    chk("rst_unknown", ld_unknown, 0);
    chk("rst_count", count, 0);
    tick();
    rst_n = 1;

    // allocation table
    for (int i = 0; i < 10; i++) begin
      alloc_req = tbl[i].req; alloc_fire = tbl[i].fire;
      #1;
      chk($sformatf("tbl%0d_ready", i), alloc_ready, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_ids", i), alloc_id, tbl[i].exp_ids);
      tick();
      alloc_req = 0; alloc_fire = 0;
      chk($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
    end
    chk("tbl_dc_valid", dc_valid, 0);

    // two committed byte stores to one word coalesce
    do_reset();
    alloc(4'b0011);
    chk("co_unknown", ld_unknown, 1);
    ex(4'd0, 32'h1000, 32'hAA, 2'd0, 6'd1);
    ex(4'd1, 32'h1001, 32'hBB, 2'd0, 6'd2);
    chk("co_resolved", ld_unknown, 0);
    chk("co_not_committed", dc_valid, 0);
    cm_valid = 4'b0011; cm_id = 16'h0010; dc_ready = 1;
    tick();
    cm_valid = 0;
    chk("co_valid", dc_valid, 1);
    chk("co_addr", dc_addr, 32'h1000);
    chk("co_be", dc_be, 4'b0011);
    chk("co_data", dc_data, 32'h0000BBAA);
    chk("co_count_before", count, 2);
    tick();
    chk("co_count_after", count, 0);
    chk("co_idle", dc_valid, 0);

    // forwarding with age ordering
    do_reset();
    alloc(4'b0011);
    ex(4'd0, 32'h2000, 32'h11223344, 2'd2, 6'd1);
    ex(4'd1, 32'h2002, 32'h55, 2'd0, 6'd2);
    load(32'h2000, 2'd2, 6'd3);
    chk("fw_lw_be", fwd_be, 4'b1111);
    chk("fw_lw_data", fwd_data, 32'h11553344);
    load(32'h2000, 2'd2, 6'd2);
    chk("fw_mid_data", fwd_data, 32'h11223344);
    load(32'h2000, 2'd2, 6'd1);
    chk("fw_none_be", fwd_be, 4'b0000);
    chk("fw_none_data", fwd_data, 32'h0);
    load(32'h2003, 2'd0, 6'd3);
    chk("fw_lb_be", fwd_be, 4'b1000);
    chk("fw_lb_data", fwd_data, 32'h11000000);
    load(32'h2004, 2'd2, 6'd3);
    chk("fw_other_word", fwd_be, 4'b0000);
    rob_head = 6'd62;
    load(32'h2000, 2'd2, 6'd3);
    chk("fw_wrap_both", fwd_data, 32'h11553344);
    load(32'h2000, 2'd2, 6'd2);
    chk("fw_wrap_one", fwd_data, 32'h11223344);
    rob_head = 6'd0;
    cm_valid = 4'b0011; cm_id = 16'h0010;
    tick();
    cm_valid = 0;
    load(32'h2000, 2'd2, 6'd1);
    chk("fw_committed_be", fwd_be, 4'b1111);
    chk("fw_committed_data", fwd_data, 32'h11553344);

    // full buffer and stalled drain
    do_reset();
    for (int i = 0; i < 4; i++) alloc(4'b1111);
    chk("full_count", count, 16);
    ex(4'd0, 32'h4000, 32'hDEADBEEF, 2'd2, 6'd1);
    cm_valid = 4'b0001; cm_id = 16'h0000;
    tick();
    cm_valid = 0;
    alloc_req = 4'b0001;
    #1;
    chk("full_ready", alloc_ready, 0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) begin
        ex_valid = 1; ex_id = 4'd1; ex_addr = 32'h4001; ex_data = 32'h77; ex_size = 2'd0; ex_rob = 6'd2;
      end
      if (k == 1) begin
        cm_valid = 4'b0001; cm_id = 16'h0001;
      end
      #1;
      chk($sformatf("stall%0d_valid", k), dc_valid, 1);
      chk($sformatf("stall%0d_addr", k), dc_addr, 32'h4000);
      chk($sformatf("stall%0d_be", k), dc_be, 4'b1111);
      chk($sformatf("stall%0d_data", k), dc_data, 32'hDEADBEEF);
      chk($sformatf("stall%0d_ready", k), alloc_ready, 0);
      tick();
      ex_valid = 0; cm_valid = 0;
    end
    dc_ready = 1;
    #1;
    chk("stall_end_be", dc_be, 4'b1111);
    chk("stall_end_data", dc_data, 32'hDEADBEEF);
    tick();
    chk("stall_pop_count", count, 15);
    chk("stall_ready_after", alloc_ready, 1);
    chk("stall_next_be", dc_be, 4'b0010);
    chk("stall_next_data", dc_data, 32'h00007700);
    tick();
    chk("stall_count2", count, 14);
    alloc_req = 0;

    // flush with a same-cycle commit
    do_reset();
    alloc(4'b1111);
    alloc(4'b0011);
    ex(4'd0, 32'h5000, 32'hA0A0A0A0, 2'd2, 6'd1);
    ex(4'd1, 32'h5004, 32'hB1B1B1B1, 2'd2, 6'd2);
    ex(4'd2, 32'h5008, 32'hC2C2C2C2, 2'd2, 6'd3);
    cm_valid = 4'b0011; cm_id = 16'h0010;
    tick();
    cm_valid = 4'b0001; cm_id = 16'h0002; flush = 1;
    tick();
    cm_valid = 0; flush = 0;
    chk("fl_count", count, 3);
    chk("fl_unknown", ld_unknown, 0);
    alloc_req = 4'b0001;
    #1;
    chk("fl_tail", alloc_id, 16'h0003);
    alloc_req = 0;
    dc_ready = 1;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk($sformatf("fl_drain%0d_valid", j), dc_valid, 1);
      chk($sformatf("fl_drain%0d_addr", j), dc_addr, 32'h5000 + 4 * j);
      chk($sformatf("fl_drain%0d_be", j), dc_be, 4'b1111);
      tick();
    end
    chk("fl_empty", count, 0);
    chk("fl_idle", dc_valid, 0);

    // move head to 15, then merge across wrap
    do_reset();
    alloc(4'b1111); alloc(4'b1111); alloc(4'b1111); alloc(4'b0111);
    for (int i = 0; i < 15; i++) ex(4'(i), 32'h100 + 4 * i, 32'(i), 2'd2, 6'(i + 1));
    dc_ready = 1;
    for (int g = 0; g < 4; g++) begin
      cm_valid = (g == 3) ? 4'b0111 : 4'b1111;
      cm_id = {4'(4*g+3), 4'(4*g+2), 4'(4*g+1), 4'(4*g)};
      if (g == 3) cm_id[15:12] = 4'd0;
      tick();
    end
    cm_valid = 0;
    for (int c = 0; c < 64 && count != 0; c++) tick();
    chk("wr_drained", count, 0);
    alloc_req = 4'b0011;
    #1;
    chk("wr_ids", alloc_id, 16'h000F);
    alloc(4'b0011);
    ex(4'd15, 32'h3000, 32'h1122, 2'd1, 6'd1);
    ex(4'd0, 32'h3002, 32'h3344, 2'd1, 6'd2);
    dc_ready = 0;
    cm_valid = 4'b0011; cm_id = 16'h000F;
    tick();
    cm_valid = 0;
    chk("wr_valid", dc_valid, 1);
    chk("wr_addr", dc_addr, 32'h3000);
    chk("wr_be", dc_be, 4'b1111);
    chk("wr_data", dc_data, 32'h33441122);
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_valid", dc_valid, 0);
    chk("async_rst_count", count, 0);
    tick();
    rst_n = 1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got 0 want 1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/coalescing_store_buffer.md
# coalescing_store_buffer

Parametrised next-generation store buffer between rename/dispatch, the store AGU, the ROB commit path and the L1 D-cache write port. Holds speculative and committed (senior) stores in allocation order and drains committed stores with per-byte masks. Merges two adjacent committed stores to the same aligned word into one D-cache write. Provides byte-granular store-to-load forwarding and flags unresolved older store addresses for memory disambiguation.

## Interface
- SB_DEPTH, 16: entries; power of two, ≥4
- ALLOC_WIDTH, 4: allocation lanes per cycle
- COMMIT_WIDTH, 4: commit lanes per cycle
- ROB_IDX_WIDTH, 6: ROB tag width
- PLEN, 32: physical address width
- XLEN, 32: data width (32 or 64); NB = XLEN/8 byte lanes
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  discard all uncommitted entries
- alloc_req_i  in  ALLOC_WIDTH  per-lane allocation request
- alloc_fire_i  in  1  perform allocation this cycle
- alloc_ready_o  out  1  all requested lanes fit
- alloc_id_o  out  ALLOC_WIDTH×log2(SB_DEPTH)  entry id per lane
- ex_valid_i  in  1  store address+data resolved
- ex_sb_id_i  in  log2(SB_DEPTH)  target entry
- ex_addr_i  in  PLEN  byte address
- ex_data_i  in  XLEN  store data, LSB-aligned
- ex_size_i  in  2  0=B, 1=H, 2=W, 3=D (D only if XLEN=64)
- ex_rob_idx_i  in  ROB_IDX_WIDTH  ROB tag
- commit_valid_i  in  COMMIT_WIDTH  per-lane commit
- commit_sb_id_i  in  COMMIT_WIDTH×log2(SB_DEPTH)  committed entry id
- dc_req_valid_o  out  1  write request
- dc_req_ready_i  in  1  D-cache accepts
- dc_req_addr_o  out  PLEN  word-aligned address (low log2(NB) bits zero)
- dc_req_data_o  out  XLEN  lane-positioned data
- dc_req_be_o  out  NB  byte enables
- ld_addr_i  in  PLEN  load byte address
- ld_size_i  in  2  load size
- ld_rob_idx_i  in  ROB_IDX_WIDTH  load ROB tag
- rob_head_i  in  ROB_IDX_WIDTH  ROB head tag
- ld_fwd_be_o  out  NB  bytes supplied by buffer
- ld_fwd_data_o  out  XLEN  forwarded bytes, lane-positioned
- ld_unknown_o  out  1  an older store has unresolved address
- count_o  out  log2(SB_DEPTH)+1  occupied entries

## Operation
- Entry: valid, committed, resolved, word address, lane data, byte mask, rob tag. Circular queue, head_ptr/tail_ptr/count.
- Alloc: n = popcount(alloc_req_i); alloc_ready_o = (count + n ≤ SB_DEPTH), registered count only. k-th set lane gets tail+k (mod DEPTH); unset lanes get 0. On fire && ready: entries valid, committed=0, resolved=0; tail += n.
- Execute: be = ((1<<2^size)−1) << addr[log2(NB)-1:0]; data shifted to same lanes; resolved=1. Misaligned stores are the producer's responsibility (not checked).
- Commit: set committed on each listed id. Commits arrive in program order, so committed entries are contiguous from head.
- Drain: head valid, committed, resolved → dc_req_valid_o. If head+1 also valid, committed, resolved, same word address and count ≥ 2: merged request, be = OR, overlapping bytes take head+1 data; acceptance pops 2, else pops 1. Request contents stay stable while valid and not ready.
- Forwarding (combinational): age(x) = x − rob_head_i (mod 2^ROB_IDX_WIDTH). Entry older than load if committed or age(tag) < age(ld_rob_idx_i). Per load byte: youngest older resolved entry with matching word address and that byte set supplies it. ld_fwd_be_o restricted to load bytes. ld_unknown_o = any valid, unresolved, uncommitted entry allocated before… determined by tag is impossible, so any valid unresolved entry sets it (conservative).
- Flush: tail ← head' + K, where K = entries committed or committing this cycle, minus any popped this cycle; head' includes a drain accepted in the flush cycle. Alloc and execute ignored during flush. Committed data preserved.

## Timing
- Reset: head=tail=count=0, all entries invalid; alloc_ready_o=1, dc_req_valid_o=0, ld_fwd_be_o=0, ld_fwd_data_o=0, ld_unknown_o=0, count_o=0. Reset mid-drain drops request immediately (async).
- Alloc, execute, commit take effect next cycle; a store committed in cycle t may drain at t+1 earliest; forwarding sees execute writes from t+1.
- Full: count=SB_DEPTH → alloc_ready_o=0 for any n>0, even if a drain fires the same cycle. n=0 → alloc_ready_o=1.
- Pointer wrap-around mod SB_DEPTH; coalescing across wrap (head=DEPTH−1, head+1=0) permitted.
- Simultaneous alloc + drain: count += n − popped. Execute to an entry being allocated the same cycle is illegal.

## Test plan
- Reset, alloc 4 lanes 1011 → ids {0,1,0,2}, count_o=3 next cycle, dc_req_valid_o=0.
- SB 0x1000 data 0xAA, SB 0x1001 data 0xBB, commit both, ready=1 → single request addr 0x1000, be=0011, data[15:0]=0xBBAA; count drops by 2.
- SW 0x2000=0x11223344 then SB 0x2002=0x55 (both older than load); LW 0x2000 → ld_fwd_be_o=1111, data 0x11553344.
- Fill 16 entries → alloc_ready_o=0; drain one with dc_req_ready_i held 0 for 3 cycles → request stable, then accepted, alloc_ready_o=1 next cycle.
- 6 entries, 2 committed, commit entry 2 and flush same cycle → count_o=3, tail=head+3; all three drain in order.
- Head at 15: SH 0x3000 (entry 15) and SH 0x3002 (entry 0) committed → one merged write be=1111 across wrap.
